// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the multiply/divide sequencer and HI/LO stage:
//   op_sel encodings, FSM state encodings and default parameter values.
// ---------------------------------------------------------------------------
package muldiv_pkg;

  // op_sel encodings presented by the control unit
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;  // reserved, behaves as OP_NONE

  // Sequencer states. Kept as plain 2-bit constants so the encoding stays
  // stable for code that probes the state register directly.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MULT_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN  = 2'd2;

  // Defaults for the datapath width and core iteration counts
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;

  // Larger of two integers; used to size the shared iteration counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_if
//   Control-unit side of the multiply/divide HI/LO stage.
//   master : control unit (drives requests and mthi/mtlo writes)
//   slave  : muldiv_hilo (returns busy/done/div_zero and HI/LO)
//
//   op_valid         request an operation this cycle
//   op_sel[1:0]      00 none, 01 MULT, 10 DIV, 11 reserved
//   rs_val, rt_val   operands A and B
//   mthi_we/mtlo_we  write HI / LO with wdata
//   wdata            mthi/mtlo data
//   busy             operation in flight, control unit must stall
//   done             one-cycle pulse, HI/LO just updated by an operation
//   div_zero         one-cycle pulse, DIV requested with rt_val == 0
//   hi_out, lo_out   architectural HI/LO
// ---------------------------------------------------------------------------
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);

  logic             op_valid;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wdata;

  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output op_valid, op_sel, rs_val, rt_val, mthi_we, mtlo_we, wdata,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  op_valid, op_sel, rs_val, rt_val, mthi_we, mtlo_we, wdata,
    output busy, done, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/hilo_regs.sv
// ---------------------------------------------------------------------------
// hilo_regs
//   Architectural HI/LO register pair.
//
//   clock                  system clock, rising edge
//   reset                  synchronous, active-low; clears HI and LO
//   capture_en             load {hi, lo} from the completing core
//   capture_hi/capture_lo  core result
//   hi_we / lo_we          mthi / mtlo write enables
//   wdata                  mthi / mtlo data
//   hi / lo                register outputs (no write-data bypass)
//
//   A capture wins over an mthi/mtlo write landing on the same edge: the
//   operation result is the architecturally later event.
// ---------------------------------------------------------------------------
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] capture_hi,
  input  logic [WIDTH-1:0] capture_lo,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // NOTE: reset is tested inside the clocked block, so it only acts on a
  // rising edge; it is deliberately absent from the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (capture_en) begin
      hi <= capture_hi;
      lo <= capture_lo;
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//   Sequencer and result stage between the control unit and the iterative
//   multiply/divide cores. Registers operands, issues a one-cycle start to
//   the selected core, counts its iterations, then captures the core's
//   hi/lo into the architectural HI/LO registers.
//
//   clock, reset          system clock; synchronous active-low reset
//   cu                    control-unit interface (slave modport)
//   mult_start/div_start  one-cycle start to the multiply / divide core
//   core_a, core_b        registered operands, shared by both cores
//   mult_hi, mult_lo      multiply core result
//   div_hi, div_lo        divide core result (remainder, quotient)
//
//   Timing for an accepted operation with N = MULT_CYCLES or DIV_CYCLES:
//     accepting edge -> N+1 busy cycles (start in the first one) -> HI/LO
//     written on the edge that ends the last busy cycle, done high for the
//     cycle after it. A new request may be accepted while done is high.
// ---------------------------------------------------------------------------
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  muldiv_hilo_if.slave     cu,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo
);

  // Counter must reach the larger of the two iteration counts.
  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             div_zero_q;

  logic             run_last;   // this edge completes the running operation
  logic [WIDTH-1:0] cap_hi;
  logic [WIDTH-1:0] cap_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             idle;
  logic             req_mult;
  logic             req_div;
  logic             req_div_zero;

  // -------------------------------------------------------------------------
  // Request decode. Requests are only seen in IDLE; while busy the control
  // unit holds the request and stalls, nothing is queued here.
  // -------------------------------------------------------------------------
  assign idle         = (state == ST_IDLE);
  assign req_mult     = idle && cu.op_valid && (cu.op_sel == OP_MULT);
  assign req_div      = idle && cu.op_valid && (cu.op_sel == OP_DIV) && (cu.rt_val != '0);
  assign req_div_zero = idle && cu.op_valid && (cu.op_sel == OP_DIV) && (cu.rt_val == '0);

  // -------------------------------------------------------------------------
  // Completion detect and result source select, both keyed on which core
  // is running.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    run_last = 1'b0;
    cap_hi   = mult_hi;
    cap_lo   = mult_lo;
    case (state)
      ST_MULT_RUN: run_last = (cnt == MULT_LAST);
      ST_DIV_RUN: begin
        run_last = (cnt == DIV_LAST);
        cap_hi   = div_hi;
        cap_lo   = div_lo;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM, iteration counter and operand registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register here
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      core_a     <= '0;
      core_b     <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      // done and div_zero are single-cycle pulses
      done_q     <= 1'b0;
      div_zero_q <= req_div_zero;

      case (state)
        ST_IDLE: begin
          if (req_mult || req_div) begin
            core_a <= cu.rs_val;
            core_b <= cu.rt_val;
            cnt    <= '0;
            state  <= req_mult ? ST_MULT_RUN : ST_DIV_RUN;
          end
        end

        ST_MULT_RUN, ST_DIV_RUN: begin
          if (run_last) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Unused encoding: recover to IDLE.
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Start strobes are decoded from state and counter: only the first RUN
  // cycle, so each core sees exactly one start per accepted operation.
  assign mult_start = (state == ST_MULT_RUN) && (cnt == '0);
  assign div_start  = (state == ST_DIV_RUN)  && (cnt == '0);

  // -------------------------------------------------------------------------
  // HI/LO registers
  // -------------------------------------------------------------------------
  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_hilo_regs (
    .clock      (clock),
    .reset      (reset),
    .capture_en (run_last),
    .capture_hi (cap_hi),
    .capture_lo (cap_lo),
    .hi_we      (cu.mthi_we),
    .lo_we      (cu.mtlo_we),
    .wdata      (cu.wdata),
    .hi         (hi_q),
    .lo         (lo_q)
  );

  // -------------------------------------------------------------------------
  // Control-unit outputs
  // -------------------------------------------------------------------------
  assign cu.busy     = !idle;
  assign cu.done     = done_q;
  assign cu.div_zero = div_zero_q;
  assign cu.hi_out   = hi_q;
  assign cu.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// ---------------------------------------------------------------------------
// tb_muldiv_hilo
//   Self-checking bench for muldiv_hilo. Stub multiply/divide cores sit on
//   the core ports and produce random values until their result is final;
//   expected HI/LO come from signed 64-bit arithmetic on the operands the
//   bench itself issued.
// ---------------------------------------------------------------------------
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 32;  // multiply iterations
  localparam int DC = 20;  // divide iterations (differs so a swap shows up)

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         mult_start, div_start;
  logic [W-1:0] core_a, core_b;
  logic [W-1:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;

  muldiv_hilo_if #(.WIDTH(W)) cu ();

  muldiv_hilo #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cu         (cu.slave),
    .mult_start (mult_start),
    .div_start  (div_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_hi     (div_hi),
    .div_lo     (div_lo)
  );

  always #5 clock = ~clock;

  // ---------------- reference arithmetic ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    p = x * y;
    return p;
  endfunction

  // returns {remainder, quotient}, truncating toward zero
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // ---------------- stub cores ----------------
  // Result becomes final on the MC-th (DC-th) edge after the start cycle
  // ends, i.e. just before the stage is due to capture it.
  int           mk = -1, dk = -1;
  logic [W-1:0] mfin_hi, mfin_lo, dfin_hi, dfin_lo;

  always @(posedge clock) begin
    if (mult_start === 1'b1) begin
      {mfin_hi, mfin_lo} <= ref_mul(core_a, core_b);
      mk <= 0;
      mult_hi <= $urandom; mult_lo <= $urandom;
    end else if (mk >= 0 && mk < MC - 2) begin
      mk <= mk + 1;
      mult_hi <= $urandom; mult_lo <= $urandom;
    end else if (mk == MC - 2) begin
      mk <= -1;
      mult_hi <= mfin_hi; mult_lo <= mfin_lo;
    end
  end

  always @(posedge clock) begin
    if (div_start === 1'b1) begin
      {dfin_hi, dfin_lo} <= ref_div(core_a, core_b);
      dk <= 0;
      div_hi <= $urandom; div_lo <= $urandom;
    end else if (dk >= 0 && dk < DC - 2) begin
      dk <= dk + 1;
      div_hi <= $urandom; div_lo <= $urandom;
    end else if (dk == DC - 2) begin
      dk <= -1;
      div_hi <= dfin_hi; div_lo <= dfin_lo;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // architectural model of HI/LO
  logic [W-1:0] m_hi = '0, m_lo = '0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and follow it to completion.
  //   b2b        : drive in the current cycle (caller sits in a done cycle)
  //   wr_accept  : also mthi in the accepting cycle
  //   mid_cycle  : busy-cycle index for an injected event (0 = none)
  //   mid_write  : injected event is mthi; otherwise a MULT request to ignore
  task automatic do_op(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit b2b, input bit wr_accept, input int mid_cycle,
                       input bit mid_write);
    logic [2*W-1:0] res;
    logic [W-1:0]   wv, wv2;
    int             cyc, n_exp;
    bit             is_mult, is_div, runs;
    is_mult = (sel == OP_MULT);
    is_div  = (sel == OP_DIV);
    runs    = is_mult || (is_div && b != '0);
    n_exp   = is_mult ? MC + 1 : DC + 1;
    wv      = $urandom;
    wv2     = $urandom;

    if (!b2b) begin
      step();
      check("done_idle", cu.done, 0);
    end
    cu.op_valid = 1'b1; cu.op_sel = sel; cu.rs_val = a; cu.rt_val = b;
    if (wr_accept) begin cu.mthi_we = 1'b1; cu.wdata = wv; end
    step();
    cu.op_valid = 1'b0; cu.op_sel = 2'($urandom); cu.rs_val = $urandom;
    cu.rt_val = $urandom; cu.mthi_we = 1'b0; cu.wdata = $urandom;
    if (wr_accept) m_hi = wv;

    check("div_zero", cu.div_zero, (is_div && b == '0));
    check("mult_start", mult_start, runs && is_mult);
    check("div_start", div_start, runs && is_div);
    check("busy_first", cu.busy, runs);
    check("hi_first", cu.hi_out, m_hi);
    check("lo_first", cu.lo_out, m_lo);

    if (!runs) begin
      step();
      check("div_zero_clear", cu.div_zero, 0);
      check("busy_idle", cu.busy, 0);
      check("hi_kept", cu.hi_out, m_hi);
      check("lo_kept", cu.lo_out, m_lo);
      return;
    end

    check("core_a", core_a, a);
    check("core_b", core_b, b);
    res = is_mult ? ref_mul(a, b) : ref_div(a, b);
    cyc = 1;
    while (1) begin
      if (cyc == mid_cycle) begin
        if (mid_write) begin
          cu.mthi_we = 1'b1; cu.wdata = wv2;
        end else begin
          cu.op_valid = 1'b1; cu.op_sel = OP_MULT; cu.rs_val = ~a; cu.rt_val = 32'd3;
        end
      end
      step();
      if (cyc == mid_cycle) begin
        cu.mthi_we = 1'b0; cu.op_valid = 1'b0;
        if (mid_write) begin
          m_hi = wv2;
          check("mthi_run", cu.hi_out, m_hi);
        end
      end
      if (cu.busy !== 1'b1) break;
      cyc++;
      check("strobes_run", {28'd0, mult_start, div_start, cu.done, cu.div_zero}, 0);
      check("core_a_stable", core_a, a);
      if (cyc > 200) begin
        check("busy_timeout", 0, 1);
        break;
      end
    end
    check("busy_cycles", cyc, n_exp);
    check("done_pulse", cu.done, 1);
    m_hi = res[2*W-1:W];
    m_lo = res[W-1:0];
    check("hi_result", cu.hi_out, m_hi);
    check("lo_result", cu.lo_out, m_lo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cu.op_valid = 1'b0; cu.op_sel = OP_NONE; cu.rs_val = '0; cu.rt_val = '0;
    cu.mthi_we = 1'b0; cu.mtlo_we = 1'b0; cu.wdata = '0;
    reset = 1'b0;
    repeat (2) step();

    // reset state
    check("rst_busy", cu.busy, 0);
    check("rst_done", cu.done, 0);
    check("rst_div_zero", cu.div_zero, 0);
    check("rst_starts", {30'd0, mult_start, div_start}, 0);
    check("rst_hi", cu.hi_out, 0);
    check("rst_lo", cu.lo_out, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
    reset = 1'b1;

    // mtlo in IDLE: visible after the next edge
    step();
    cu.mtlo_we = 1'b1; cu.wdata = 32'h0BAD_F00D;
    step();
    cu.mtlo_we = 1'b0;
    m_lo = 32'h0BAD_F00D;
    check("mtlo_idle", cu.lo_out, m_lo);
    check("mtlo_hi_untouched", cu.hi_out, m_hi);

    // MULT 7 x -3
    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, 0);
    check("mult_hi_lit", cu.hi_out, 32'hFFFF_FFFF);
    check("mult_lo_lit", cu.lo_out, 32'hFFFF_FFEB);
    step();
    check("done_once", cu.done, 0);

    // DIV 100 / 7
    do_op(OP_DIV, 32'd100, 32'd7, 0, 0, 0, 0);
    check("div_lo_lit", cu.lo_out, 32'd14);
    check("div_hi_lit", cu.hi_out, 32'd2);

    // DIV by zero with HI preset via mthi
    step();
    cu.mthi_we = 1'b1; cu.wdata = 32'h0000_1234;
    step();
    cu.mthi_we = 1'b0;
    m_hi = 32'h0000_1234;
    check("mthi_idle", cu.hi_out, m_hi);
    do_op(OP_DIV, 32'd55, 32'd0, 0, 0, 0, 0);
    check("div0_hi_lit", cu.hi_out, 32'h0000_1234);

    // MULT request ignored during DIV, then MULT back-to-back on done
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd9, 0, 0, 5, 0);
    do_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 0, 0);

    // mthi during MULT_RUN, overwritten at completion
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 5, 1);

    // mthi in the same cycle as an accepted op
    do_op(OP_MULT, 32'd123456, 32'd654321, 0, 1, 0, 0);

    // none / reserved requests are ignored
    do_op(OP_NONE, 32'd5, 32'd6, 0, 0, 0, 0);
    do_op(OP_RSVD, 32'd5, 32'd6, 0, 0, 0, 0);

    // reset in the middle of a MULT
    step();
    cu.op_valid = 1'b1; cu.op_sel = OP_MULT; cu.rs_val = 32'd77; cu.rt_val = 32'd88;
    step();
    cu.op_valid = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    check("mid_rst_busy", cu.busy, 0);
    check("mid_rst_hi", cu.hi_out, 0);
    check("mid_rst_lo", cu.lo_out, 0);
    check("mid_rst_done", cu.done, 0);
    step();
    check("mid_rst_done2", cu.done, 0);
    check("mid_rst_busy2", cu.busy, 0);
    do_op(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 0, 0, 0, 0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   s;
      logic [W-1:0] a, b;
      int           kind, mid;
      bit           prev_ran;
      kind = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (kind < 4)       s = OP_MULT;
      else if (kind < 8)  s = OP_DIV;
      else if (kind == 8) begin s = OP_DIV; b = '0; end
      else                s = 2'($urandom_range(0, 1)) == 0 ? OP_NONE : OP_RSVD;
      if (s == OP_DIV && b != '0 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 50));
      mid = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 10));
      prev_ran = (cu.done === 1'b1);
      do_op(s, a, b, prev_ran && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) == 0,
            mid, $urandom_range(0, 1) == 1);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
